// File: rtl/sccb_config_sequencer.sv
// rtl/sccb_config_sequencer.sv - walks a ROM register table and issues SCCB writes
module sccb_config_sequencer #(
  parameter logic [6:0] DEVICE_ADDR    = 7'h21,
  parameter int         ROM_AW         = 8,
  parameter int         DELAY_CYCLES   = 270000,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter int         MAX_RETRY      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic [6:0]        o_dev_addr,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_rd_wr,
  output logic              o_enable,
  input  logic              i_ready,
  input  logic              i_nack
);

  localparam int DW = (DELAY_CYCLES < 2) ? 1 : $clog2(DELAY_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  // Delay counter runs down to zero, so it is loaded with one less than the span.
  localparam logic [DW-1:0]     DELAY_LOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0]     TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]     RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [ROM_AW-1:0] IDX_LAST   = '1;

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ROM_WAIT,
    S_DECODE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [ROM_AW-1:0] idx;
  logic [DW-1:0]     delay_cnt;
  logic [TW-1:0]     to_cnt;
  logic [RW-1:0]     retry_cnt;

  assign o_dev_addr = DEVICE_ADDR;
  assign o_rd_wr    = 1'b0;

  // Table walker: fetch, decode, handshake with the master, retry and time out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      delay_cnt  <= '0;
      to_cnt     <= '0;
      retry_cnt  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_enable   <= 1'b0;
      o_rom_addr <= '0;
      o_reg_addr <= '0;
      o_wr_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            idx     <= '0;
            o_done  <= 1'b0;
            o_error <= 1'b0;
            o_busy  <= 1'b1;
            state   <= S_FETCH;
          end
        end

        S_FETCH: begin
          o_rom_addr <= idx;
          state      <= S_ROM_WAIT;
        end

        // The ROM registers its output one cycle after the address.
        S_ROM_WAIT: state <= S_DECODE;

        S_DECODE: begin
          if (i_rom_data == ENTRY_END) begin
            state <= S_DONE;
          end else if (i_rom_data == ENTRY_DELAY) begin
            delay_cnt <= DELAY_LOAD;
            state     <= S_DELAY;
          end else begin
            o_reg_addr <= i_rom_data[15:8];
            o_wr_data  <= i_rom_data[7:0];
            retry_cnt  <= '0;
            to_cnt     <= '0;
            state      <= S_ISSUE;
          end
        end

        // Request only once the master reports idle.
        S_ISSUE: begin
          if (i_ready) begin
            o_enable <= 1'b1;
            to_cnt   <= '0;
            state    <= S_WAIT_BUSY;
          end else if (to_cnt == TO_LAST) begin
            state <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        // Hold the request until the master shows it has taken it.
        S_WAIT_BUSY: begin
          if (!i_ready) begin
            o_enable <= 1'b0;
            to_cnt   <= '0;
            state    <= S_WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            o_enable <= 1'b0;
            state    <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (i_ready) begin
            if (!i_nack) begin
              state <= S_NEXT;
            end else if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              to_cnt    <= '0;
              state     <= S_ISSUE;
            end else begin
              state <= S_ERROR;
            end
          end else if (to_cnt == TO_LAST) begin
            state <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_DELAY: begin
          if (delay_cnt == '0) begin
            state <= S_NEXT;
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end

        // The last table slot ends the walk even without an end marker.
        S_NEXT: begin
          if (idx == IDX_LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end

        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end

        // o_rom_addr is left untouched so it names the failing entry.
        S_ERROR: begin
          o_error  <= 1'b1;
          o_busy   <= 1'b0;
          o_enable <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb/tb_sccb_config_sequencer.sv - self-checking bench for sccb_config_sequencer
module tb_sccb_config_sequencer;

  localparam int ROM_AW = 2;
  localparam int DELAY  = 20;
  localparam int TMO    = 40;
  localparam int MAXR   = 3;
  localparam int BOUND  = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error, enable, rd_wr;
  logic [1:0]  rom_addr;
  logic [15:0] rom_q;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr, wr_data;
  logic        ready = 1'b1;
  logic        nack = 1'b0;

  logic [15:0] rom [4];
  int          cyc = 0;

  int n_vec = 0;
  int n_fail = 0;

  logic [15:0] sb_q[$];
  int          m_cap_cyc[$];
  int          m_rise_cyc[$];
  int          m_cnt = 0;
  int          m_attempts = 0;
  int          m_nack_first = 0;
  bit          m_nack_all = 1'b0;
  bit          m_stuck = 1'b0;

  sccb_config_sequencer #(
    .DEVICE_ADDR   (7'h21),
    .ROM_AW        (ROM_AW),
    .DELAY_CYCLES  (DELAY),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MAXR)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_error   (error),
    .o_rom_addr(rom_addr),
    .i_rom_data(rom_q),
    .o_dev_addr(dev_addr),
    .o_reg_addr(reg_addr),
    .o_wr_data (wr_data),
    .o_rd_wr   (rd_wr),
    .o_enable  (enable),
    .i_ready   (ready),
    .i_nack    (nack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q <= rom[rom_addr];
    cyc   <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master model: takes a request when idle, stays busy 3 cycles, then reports ack/nack.
  always @(negedge clk) begin
    if (!m_stuck) begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          ready = 1'b1;
          nack  = m_nack_all || (m_attempts <= m_nack_first);
          m_rise_cyc.push_back(cyc);
        end
      end else if (enable && ready) begin
        m_attempts++;
        m_cap_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_write: got %0h expected none", {reg_addr, wr_data});
        end else begin
          chk("write", {reg_addr, wr_data}, sb_q.pop_front());
        end
        ready = 1'b0;
        nack  = 1'b0;
        m_cnt = 3;
      end
    end
  end

  typedef struct {
    logic [3:0][15:0] tbl;
    int               nack_first;
    bit               nack_all;
    bit               stuck;
    int               n_w;
    logic [3:0][15:0] w;
    bit               exp_done;
    bit               exp_err;
    logic [1:0]       exp_addr;
    bit               chk_delay;
  } vec_t;

  vec_t vt[7];

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int b = 0;
    while (!((done || error) && !busy) && b < BOUND) begin
      @(negedge clk);
      b++;
    end
    if (b >= BOUND) chk({name, "_finish_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int i);
    int t0;
    for (int k = 0; k < 4; k++) rom[k] = vt[i].tbl[k];
    m_stuck      = vt[i].stuck;
    m_nack_all   = vt[i].nack_all;
    m_nack_first = vt[i].nack_first;
    m_attempts   = 0;
    m_cap_cyc.delete();
    m_rise_cyc.delete();
    for (int k = 0; k < vt[i].n_w; k++) sb_q.push_back(vt[i].w[k]);
    t0 = cyc;
    pulse_start();
    wait_finish($sformatf("v%0d", i));
    repeat (6) @(negedge clk);
    chk($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].exp_done));
    chk($sformatf("v%0d_error", i), 32'(error), 32'(vt[i].exp_err));
    chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
    chk($sformatf("v%0d_enable", i), 32'(enable), 32'd0);
    chk($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vt[i].exp_addr));
    chk($sformatf("v%0d_writes_left", i), sb_q.size(), 32'd0);
    if (vt[i].chk_delay) begin
      if (m_cap_cyc.size() >= 2 && m_rise_cyc.size() >= 1)
        chk($sformatf("v%0d_delay_gap", i), 32'(m_cap_cyc[1] - m_rise_cyc[0] >= DELAY), 32'd1);
      else
        chk($sformatf("v%0d_delay_gap_missing", i), 32'(m_cap_cyc.size()), 32'd2);
    end
    if (vt[i].stuck) chk($sformatf("v%0d_timeout_span", i), 32'(cyc - t0 >= TMO), 32'd1);
    sb_q.delete();
    m_stuck = 1'b0;
    m_nack_all = 1'b0;
    m_nack_first = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b;
    for (int k = 0; k < 4; k++) rom[k] = 16'hFFFF;

    // Vector table: ROM contents, master behaviour and required outcome.
    vt[0] = '{tbl: {16'hFFFF, 16'h1204, 16'hFFF0, 16'h1280}, nack_first: 0, nack_all: 0, stuck: 0,
              n_w: 2, w: {16'h0, 16'h0, 16'h1204, 16'h1280}, exp_done: 1, exp_err: 0, exp_addr: 2'd3, chk_delay: 1};
    vt[1] = '{tbl: {16'h0, 16'h0, 16'hFFFF, 16'h3A04}, nack_first: 2, nack_all: 0, stuck: 0,
              n_w: 3, w: {16'h0, 16'h3A04, 16'h3A04, 16'h3A04}, exp_done: 1, exp_err: 0, exp_addr: 2'd1, chk_delay: 0};
    vt[2] = '{tbl: {16'h0, 16'h0, 16'hFFFF, 16'h3A04}, nack_first: 0, nack_all: 1, stuck: 0,
              n_w: 4, w: {16'h3A04, 16'h3A04, 16'h3A04, 16'h3A04}, exp_done: 0, exp_err: 1, exp_addr: 2'd0, chk_delay: 0};
    vt[3] = '{tbl: {16'h0, 16'h0, 16'hFFFF, 16'h1111}, nack_first: 0, nack_all: 0, stuck: 1,
              n_w: 0, w: '0, exp_done: 0, exp_err: 1, exp_addr: 2'd0, chk_delay: 0};
    vt[4] = '{tbl: {16'h0404, 16'h0303, 16'h0202, 16'h0101}, nack_first: 0, nack_all: 0, stuck: 0,
              n_w: 4, w: {16'h0404, 16'h0303, 16'h0202, 16'h0101}, exp_done: 1, exp_err: 0, exp_addr: 2'd3, chk_delay: 0};
    vt[5] = '{tbl: {16'h5555, 16'h5555, 16'h5555, 16'hFFFF}, nack_first: 0, nack_all: 0, stuck: 0,
              n_w: 0, w: '0, exp_done: 1, exp_err: 0, exp_addr: 2'd0, chk_delay: 0};
    vt[6] = '{tbl: {16'h0C0D, 16'hFFF0, 16'hFFF0, 16'h0A0B}, nack_first: 0, nack_all: 0, stuck: 0,
              n_w: 2, w: {16'h0, 16'h0, 16'h0C0D, 16'h0A0B}, exp_done: 1, exp_err: 0, exp_addr: 2'd3, chk_delay: 0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("dev_addr", 32'(dev_addr), 32'h21);
    chk("rd_wr", 32'(rd_wr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Start latency: busy next cycle, address the cycle after, earliest enable after DECODE.
    rom[0] = 16'h1280;
    rom[1] = 16'hFFFF;
    sb_q.push_back(16'h1280);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_addr_hold", 32'(rom_addr), 32'd3);
    @(negedge clk);
    chk("lat_addr0", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    chk("lat_enable_early", 32'(enable), 32'd0);
    @(negedge clk);
    chk("lat_enable", 32'(enable), 32'd1);
    chk("lat_reg_addr", 32'(reg_addr), 32'h12);
    chk("lat_wr_data", 32'(wr_data), 32'h80);
    wait_finish("lat");
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_writes_left", sb_q.size(), 32'd0);
    repeat (4) @(negedge clk);

    // Reset during WAIT_DONE of entry 1, with start coincident with reset.
    rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'h0303; rom[3] = 16'hFFFF;
    m_attempts = 0;
    sb_q.push_back(16'h0101);
    sb_q.push_back(16'h0202);
    pulse_start();
    b = 0;
    while (m_attempts < 2 && b < BOUND) begin
      @(negedge clk);
      b++;
    end
    if (b >= BOUND) chk("mid_reach_entry1", 32'(m_attempts), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_error", 32'(error), 32'd0);
    chk("mid_enable", 32'(enable), 32'd0);
    chk("mid_rom_addr", 32'(rom_addr), 32'd0);
    chk("mid_reg_addr", 32'(reg_addr), 32'd0);
    chk("mid_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("mid_start_ignored", 32'(busy), 32'd0);
    b = 0;
    while (!ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    repeat (2) @(negedge clk);
    sb_q.delete();
    sb_q.push_back(16'h0101);
    sb_q.push_back(16'h0202);
    sb_q.push_back(16'h0303);
    pulse_start();
    wait_finish("rerun");
    repeat (6) @(negedge clk);
    chk("rerun_done", 32'(done), 32'd1);
    chk("rerun_error", 32'(error), 32'd0);
    chk("rerun_rom_addr", 32'(rom_addr), 32'd3);
    chk("rerun_writes_left", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
